// File: rtl/bool2a_inverse_scan.sv
// Inverse solver for e = (~a|~b)&~c: walks all 8 {a,b,c} triples and streams every match.
// Optional abort input is enabled by defining BOOL2A_SCAN_ABORT_EN.
module bool2a_inverse_scan #(
   parameter int DWELL = 0,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             target,
   input  logic             out_ready,
`ifdef BOOL2A_SCAN_ABORT_EN
   input  logic             abort,
`endif
   output logic             out_valid,
   output logic [2:0]       out_abc,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt
);

   typedef enum logic [1:0] {IDLE, EVAL, EMIT, DONE} state_t;

   state_t           state, state_nxt;
   logic [2:0]       idx;
   logic [7:0]       dwell_cnt;
   logic             target_q;
   logic [2:0]       abc_q;
   logic [CNT_W-1:0] match_cnt_q;
   logic             dwell_done;
   logic             cand_hit;
   logic             abort_hit;

   assign dwell_done = (dwell_cnt == 8'(DWELL));
   assign cand_hit   = (((~idx[2] | ~idx[1]) & ~idx[0]) == target_q);

`ifdef BOOL2A_SCAN_ABORT_EN
   assign abort_hit = abort && ((state == EVAL) || (state == EMIT));
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = EVAL;
         EVAL: begin
            if (abort_hit)
               state_nxt = DONE;
            else if (dwell_done) begin
               if (cand_hit)          state_nxt = EMIT;
               else if (idx == 3'd7)  state_nxt = DONE;
            end
         end
         EMIT: begin
            if (abort_hit)
               state_nxt = DONE;
            else if (out_ready)
               state_nxt = (idx == 3'd7) ? DONE : EVAL;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         dwell_cnt   <= '0;
         target_q    <= 1'b0;
         abc_q       <= '0;
         match_cnt_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  target_q    <= target;
                  idx         <= '0;
                  dwell_cnt   <= '0;
                  match_cnt_q <= '0;
               end
            end
            EVAL: begin
               if (!abort_hit) begin
                  if (!dwell_done)
                     dwell_cnt <= dwell_cnt + 8'd1;
                  else begin
                     dwell_cnt <= '0;
                     if (cand_hit)
                        abc_q <= idx;
                     else if (idx != 3'd7)
                        idx <= idx + 3'd1;
                  end
               end
            end
            EMIT: begin
               // An aborted emit is dropped without counting, even if the handshake coincides.
               if (!abort_hit && out_ready) begin
                  match_cnt_q <= match_cnt_q + CNT_W'(1);
                  if (idx != 3'd7) idx <= idx + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      out_valid = (state == EMIT);
      busy      = (state != IDLE);
      done      = (state == DONE);
   end

   assign out_abc   = abc_q;
   assign match_cnt = match_cnt_q;

endmodule

// File: doc/bool2a_inverse_scan.md
Name: bool2a_inverse_scan

Overview:
- Inverse of the bool2A function e = (~a|~b)&~c. Given a target value of e, the block scans all 8 input triples (a,b,c). It emits every triple that produces the target over a valid/ready stream.
- Sits beside the combinational bool2A logic as a lab solver/checker. Feeds LEDs or a downstream logger.

Parameters:
- DWELL, default 0: extra wait cycles spent per candidate before it is evaluated; range 0..255.
- CNT_W, default 4: width of match_cnt; must be at least 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin scan; sampled only in IDLE.
- target  input  1  required value of e; latched when start is accepted.
- out_ready  input  1  downstream accepts out_abc.
- out_valid  output  1  out_abc holds a matching triple.
- out_abc  output  3  {a,b,c} of the match; a is the MSB.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at scan end.
- match_cnt  output  CNT_W  matches accepted in the current or last scan.

Behaviour:
- Reset and polarity: reset is asynchronous and active-low on rst_n, with the single clock clk.
- While rst_n=0: state=IDLE, idx=0, dwell counter=0, out_valid=0, out_abc=0, busy=0, done=0, match_cnt=0, latched target=0.
- Reset asserted mid-scan aborts immediately. No partial output survives.
- Candidate mapping: idx is a 3-bit counter; a=idx[2], b=idx[1], c=idx[0]. f(idx)=(~a|~b)&~c.
- IDLE:
  - On start=1: latch target, idx<=0, dwell<=0, match_cnt<=0, go to EVAL.
  - start is ignored in every other state.
- EVAL:
  - If dwell<DWELL: dwell++ and stay.
  - Otherwise dwell<=0, then:
    - f(idx)==target: out_abc<=idx, out_valid<=1, go to EMIT.
    - no match and idx==7: go to DONE.
    - no match and idx<7: idx++, stay in EVAL.
- EMIT:
  - out_valid=1. out_abc and out_valid stay stable until out_valid&out_ready.
  - On handshake: out_valid<=0, match_cnt++; then go to DONE if idx==7, else idx++ and go to EVAL.
  - out_ready is ignored outside EMIT.
- DONE: done=1 for exactly one cycle, then IDLE. match_cnt holds until the next accepted start.
- Timing with out_ready tied high: done is asserted 8*(DWELL+1)+m+1 cycles after the start edge, where m is the number of matches.
- idx does not wrap; the scan ends at 7.
- Expected match sets:
  - target=1 gives 000, 010, 100 (m=3).
  - target=0 gives 001, 011, 101, 110, 111 (m=5).
- A start pulse on the same cycle as done is ignored; the block is not yet in IDLE.

Optional Feature:
- Macro: BOOL2A_SCAN_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in EVAL or EMIT sends the block to DONE on the next edge, clears out_valid and freezes match_cnt. An EMIT that has not completed its handshake is not counted.
  - abort in IDLE or DONE has no effect. abort has priority over a simultaneous handshake; that triple is not counted.
- When not defined: no abort port; every scan runs to idx=7.

Test Plan:
- Reset: hold rst_n=0 mid-scan at any cycle -> all outputs 0 in the same cycle; state IDLE after release.
- DWELL=0, out_ready=1, target=1, pulse start -> triples 000, 010, 100 in order; done 12 cycles after start; match_cnt=3.
- DWELL=0, out_ready=1, target=0 -> triples 001, 011, 101, 110, 111; done at cycle 14; match_cnt=5.
- Backpressure: target=1, out_ready=0 for 5 cycles on the first match -> out_abc=000 held stable with out_valid=1; no idx advance; done delayed by 5 cycles.
- DWELL=2, target=1 -> done at cycle 8*3+3+1=28; start pulsed while busy is ignored, and match_cnt never resets mid-scan.
- With BOOL2A_SCAN_ABORT_EN: abort during the second EMIT with out_ready=0 -> done next cycle; match_cnt=1; out_valid=0.
